// File: rtl/stream_pkg.sv
// Shared constants, types and helpers for the stream width packer.
//   MAX_RATIO   - largest supported narrow-beats-per-wide-beat ratio
//   lane_idx_w  - bit width of a lane index for a given ratio
//   keep_max_t  - keep vector sized for the largest supported ratio
package stream_pkg;

  localparam int unsigned MAX_RATIO = 16;

  function automatic int unsigned lane_idx_w(input int unsigned ratio);
    return $clog2(ratio);
  endfunction

  typedef logic [MAX_RATIO-1:0] keep_max_t;

endpackage

// File: rtl/stream_out_slot.sv
// Single-entry registered output slot with ready/valid on both sides.
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   load_valid/load_ready  - write side; load_ready = slot empty or draining
//   load_data              - word captured on a load transfer
//   out_valid/out_ready    - read side handshake
//   out_data               - held word, stable while stalled
module stream_out_slot #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign load_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_valid && load_ready) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_width_packer.sv
// Packs RATIO consecutive DATA_WIDTH-bit ready/valid beats into one wide
// beat with a per-lane keep mask; in_last flushes a partial wide beat early.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   in_valid/in_ready    - narrow input handshake
//   in_data, in_last     - narrow payload and end-of-frame flag
//   out_valid/out_ready  - wide output handshake
//   out_data             - packed payload, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   out_keep             - bit k set when lane k holds data
//   out_last             - wide beat closes a frame
module stream_width_packer
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RATIO      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_last
);

  localparam int unsigned IDX_W  = lane_idx_w(RATIO);
  localparam int unsigned WIDE_W = DATA_WIDTH * RATIO;
  localparam int unsigned SLOT_W = WIDE_W + RATIO + 1;

  if (RATIO < 2 || RATIO > MAX_RATIO) begin : g_ratio_check
    $error("stream_width_packer: RATIO must be in 2..16");
  end

  typedef logic [RATIO-1:0] keep_t;

  logic [IDX_W-1:0]  idx;
  logic [WIDE_W-1:0] acc;
  keep_t             acc_keep;

  logic              accept;
  logic              emit;
  keep_t             lane_bit;
  logic [WIDE_W-1:0] wide_data;
  logic [SLOT_W-1:0] slot_d;
  logic [SLOT_W-1:0] slot_q;

  assign accept = in_valid && in_ready;
  assign emit   = accept && (in_last || idx == IDX_W'(RATIO - 1));

  // Lanes below idx come from the accumulator, lane idx takes in_data and
  // everything above is zero. The same word serves as the next accumulator
  // on a collect beat, so only one lane mux exists.
  always_comb begin
    lane_bit  = keep_t'(1) << idx;
    wide_data = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (acc_keep[k]) begin
        wide_data[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (lane_bit[k]) begin
        wide_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      acc      <= '0;
      acc_keep <= '0;
    end else if (emit) begin
      idx      <= '0;
      acc      <= '0;
      acc_keep <= '0;
    end else if (accept) begin
      idx      <= idx + 1'b1;
      acc      <= wide_data;
      acc_keep <= acc_keep | lane_bit;
    end
  end

  assign slot_d = {wide_data, acc_keep | lane_bit, in_last};

  stream_out_slot #(
    .WIDTH(SLOT_W)
  ) u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .load_valid(emit),
    .load_ready(in_ready),
    .load_data (slot_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (slot_q)
  );

  assign {out_data, out_keep, out_last} = slot_q;

endmodule

// File: doc/stream_width_packer.md
Name: stream_width_packer

Overview:
- Downstream consumer of the pipeline_register stage.
- Gathers RATIO consecutive DATA_WIDTH-bit ready/valid beats into one wide beat of RATIO*DATA_WIDTH bits.
- Per-lane keep mask plus a last flag, so a frame ending on a partial word flushes early.
- Feeds wide datapath consumers (wide FIFOs, memory-write ports) at 1/RATIO of the narrow beat rate.

Parameters:
- DATA_WIDTH, 32, width of one narrow input beat.
- RATIO, 2, narrow beats per wide beat; legal range 2..16; elaboration error outside it.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  packer accepts the beat this cycle.
- in_data  input  DATA_WIDTH  narrow payload.
- in_last  input  1  final beat of the frame; qualified by in_valid.
- out_valid  output  1  wide beat valid.
- out_ready  input  1  downstream accepts the wide beat.
- out_data  output  DATA_WIDTH*RATIO  packed payload; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_keep  output  RATIO  bit k set = lane k holds valid data.
- out_last  output  1  wide beat closes a frame.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - Lane index idx=0; accumulator and accumulated keep = 0.
  - Any partial word is discarded, including on reset mid-frame or mid-stall.
- Transfers:
  - Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
  - in_ready = !out_valid || out_ready. Combinational path out_ready -> in_ready is permitted; no other combinational input-to-output path.
  - in_ready never depends on in_valid or in_last.
- State is idx, 0..RATIO-1, with two behaviours:
  - COLLECT (accepted beat has idx < RATIO-1 and in_last=0): write in_data to accumulator lane idx, set keep bit idx, idx <= idx+1. Outputs unchanged, except that out_valid clears if an output transfer happens in the same cycle.
  - EMIT (accepted beat has idx == RATIO-1 or in_last=1):
    - out_data <= accumulator with lane idx = in_data; lanes above idx forced to 0.
    - out_keep <= accumulated keep | (1<<idx).
    - out_last <= in_last; out_valid <= 1.
    - Accumulator, keep and idx all cleared to 0.
- Latency: output registered; the wide beat is visible the cycle after the accepting edge of its final narrow beat.
- Throughput: with out_ready held high, no bubbles; RATIO input beats per output beat.
- Simultaneous EMIT and output transfer: the new wide beat replaces the old one; out_valid stays 1.
- Stall: while out_valid && !out_ready, out_data/out_keep/out_last hold stable and in_ready=0, so even a COLLECT beat is back-pressured.
- in_last on lane 0 gives a single-lane beat: keep = 1, out_last = 1.
- out_keep is always contiguous from lane 0. out_last=1 only on EMIT caused by in_last.
- in_valid low: no state change. X on in_data while in_valid=0 must not propagate to outputs.

Decomposition:
- Package stream_pkg:
  - constant MAX_RATIO=16.
  - function lane_idx_w(ratio) returning $clog2(ratio).
  - typedef for the keep vector parameterised via the module.
- One sub-module: stream_out_slot, the single-entry output register holding data/keep/last with ready/valid and in_ready generation; the packer instantiates it with width DATA_WIDTH*RATIO+RATIO+1.
- Lane accumulation stays in the top module.

Test Plan (DATA_WIDTH=32, RATIO=2 unless noted):
1. Reset with out_ready=0 and in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_keep=0, out_data=0, in_ready=1; no beat captured while rst low.
2. Beats 32'hAAAA_BBBB then 32'h1111_2222, out_ready=1 -> one cycle after the second accept: out_data=64'h1111_2222_AAAA_BBBB, out_keep=2'b11, out_last=0; back-to-back frames show no bubble.
3. Single beat 32'h3333_4444 with in_last=1 -> out_data=64'h0000_0000_3333_4444, out_keep=2'b01, out_last=1, idx back to 0.
4. Complete a wide beat with out_ready=0, then offer 32'h5555_6666 -> in_ready=0 and outputs frozen for 3 cycles; raise out_ready -> old beat drains, new beat accepted the same cycle.
5. RATIO=4: four beats 1,2,3,4 (last on 4th) -> out_data=128'h4_3_2_1 by lane, out_keep=4'hF, out_last=1; then three beats 5,6,7 with last on 7 -> keep=4'b0111, lane3=0.
6. Assert rst after one lane accumulated and again during a stalled output -> outputs zero immediately; next full pair packs from lane 0 with no stale data.
